// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: D = A - B - bin over NIBBLES*4 bits, one 4-bit borrow-lookahead
// slice per clock, LSB nibble first. Results appear only on the completion edge.
module nibble_serial_subtractor #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [4*NIBBLES-1:0]   a_i,
  input  logic [4*NIBBLES-1:0]   b_i,
  input  logic                   bin_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES-1:0]   d_o,
  output logic                   bout_o
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [W-1:0]    d_q, d_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [3:0] sl_a, sl_b, sl_g, sl_p, sl_d;
  logic [4:0] sl_c;
  logic       last_slice;

  // Borrow-lookahead slice on the current low nibble of the shifting operand regs.
  always_comb begin
    sl_a    = a_q[3:0];
    sl_b    = b_q[3:0];
    sl_g    = ~sl_a & sl_b;
    sl_p    = ~sl_a | sl_b;
    sl_c[0] = borrow_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_d    = sl_a ^ sl_b ^ sl_c[3:0];
  end

  assign last_slice = (cnt_q == CntW'(NIBBLES - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d  = StRun;
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = bin_i;
          cnt_d    = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
        diff_d   = (diff_q >> 4) | (W'(sl_d) << (W - 4));
        borrow_d = sl_c[4];
        cnt_d    = cnt_q + CntW'(1);
        if (last_slice) begin
          state_d = StDone;
          d_d     = diff_d;
          bout_d  = sl_c[4];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign d_o    = d_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: vector table, multi-cycle corner sequences, and
// random operations against an arithmetic model {bout,d} = A - B - bin.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done;
  logic [15:0] d;
  logic        bout;

  logic        s1_start;
  logic [3:0]  s1_a, s1_b;
  logic        s1_bin;
  logic        s1_busy, s1_done;
  logic [3:0]  s1_d;
  logic        s1_bout;

  int errors = 0;
  int checks = 0;

  nibble_serial_subtractor #(.NIBBLES(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .bin_i  (bin),
    .busy_o (busy),
    .done_o (done),
    .d_o    (d),
    .bout_o (bout)
  );

  nibble_serial_subtractor #(.NIBBLES(1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(s1_start),
    .a_i    (s1_a),
    .b_i    (s1_b),
    .bin_i  (s1_bin),
    .busy_o (s1_busy),
    .done_o (s1_done),
    .d_o    (s1_d),
    .bout_o (s1_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
  } vec_t;

  vec_t vecs[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, scramble inputs after accept, wait a bounded time for done.
  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                        output logic [15:0] dd, output logic bo, output int lat,
                        output logic busy_after_accept);
    a = ai; b = bi; bin = ci; start = 1'b1;
    cyc();
    busy_after_accept = busy;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat = 99;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (done) begin
        lat = i;
        break;
      end
    end
    dd = d;
    bo = bout;
  endtask

  initial begin
    logic [15:0] rd;
    logic        rb, rbusy;
    int          lat, ndone, dt;
    logic [15:0] ra, rbb, dsave;
    logic        rbin, bsave;
    logic [16:0] full;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_bin = 1'b0;
    repeat (2) cyc();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_d", 32'(d), 32'h0);
    chk("reset_bout", 32'(bout), 32'h0);
    rst_n = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb, lat, rbusy);
      chk($sformatf("vec%0d_busy", i), 32'(rbusy), 32'h1);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_d", i), 32'(rd), 32'(vecs[i].d));
      chk($sformatf("vec%0d_bout", i), 32'(rb), 32'(vecs[i].bout));
      cyc();
      chk($sformatf("vec%0d_done_once", i), 32'(done), 32'h0);
    end

    // start pulsed mid-RUN with different operands must be ignored
    a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
    cyc();
    start = 1'b0;
    ndone = 0; dt = 0; dsave = '0; bsave = 1'b0;
    for (int t = 3; t <= 10; t++) begin
      cyc();
      if (done) begin
        ndone++;
        dt = t;
        dsave = d;
        bsave = bout;
      end
    end
    chk("midrun_ndone", 32'(ndone), 32'd1);
    chk("midrun_lat", 32'(dt), 32'd4);
    chk("midrun_d", 32'(dsave), 32'h1000);
    chk("midrun_bout", 32'(bsave), 32'h0);

    // start held high: accepted in each DONE cycle, done every 5 cycles
    a = 16'h0F0F; b = 16'h0101; bin = 1'b0; start = 1'b1;
    cyc();
    ndone = 0;
    for (int t = 1; t <= 14; t++) begin
      cyc();
      if (done) begin
        ndone++;
        chk("held_done_time", 32'(t), 32'(5 * ndone - 1));
        chk("held_d", 32'(d), 32'h0E0E);
      end
    end
    start = 1'b0;
    chk("held_ndone", 32'(ndone), 32'd3);
    cyc();
    chk("held_idle_busy", 32'(busy), 32'h0);
    chk("held_idle_done", 32'(done), 32'h0);

    // reset asserted in the second RUN cycle aborts the operation
    a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rstrun_busy", 32'(busy), 32'h0);
    chk("rstrun_done", 32'(done), 32'h0);
    chk("rstrun_d", 32'(d), 32'h0);
    chk("rstrun_bout", 32'(bout), 32'h0);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      cyc();
      if (done || busy) ndone++;
    end
    chk("rstrun_no_done", 32'(ndone), 32'd0);

    // single-nibble instance
    s1_a = 4'h3; s1_b = 4'h5; s1_bin = 1'b0; s1_start = 1'b1;
    cyc();
    s1_start = 1'b0; s1_a = 4'h0; s1_b = 4'h0;
    chk("n1_busy", 32'(s1_busy), 32'h1);
    cyc();
    chk("n1_done", 32'(s1_done), 32'h1);
    chk("n1_d", 32'(s1_d), 32'hE);
    chk("n1_bout", 32'(s1_bout), 32'h1);

    // random ops, occasional idle gaps, otherwise back-to-back from DONE
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom); rbb = 16'($urandom); rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rbb} - 17'(rbin);
      run_op(ra, rbb, rbin, rd, rb, lat, rbusy);
      chk("rand", {lat[7:0], 7'b0, rb, rd}, {8'd4, 7'b0, full[16], full[15:0]});
      if (($urandom % 4) == 0) repeat ($urandom_range(1, 2)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
